// File: rtl/rbm_pkg.sv
// Shared definitions for the RBM parameter loader: segment encoding and
// segment/frame length helpers used by the loader and its bench.
package rbm_pkg;

    localparam int unsigned SEG_W = 3;

    localparam logic [SEG_W-1:0] SEG_IMG = 3'd0;
    localparam logic [SEG_W-1:0] SEG_HW  = 3'd1;
    localparam logic [SEG_W-1:0] SEG_HB  = 3'd2;
    localparam logic [SEG_W-1:0] SEG_CW  = 3'd3;
    localparam logic [SEG_W-1:0] SEG_CB  = 3'd4;

    // Number of stream words carried by one segment.
    function automatic int unsigned seg_len(input logic [SEG_W-1:0] seg,
                                            input int unsigned in_dim,
                                            input int unsigned h_dim,
                                            input int unsigned out_dim);
        case (seg)
            SEG_IMG: seg_len = in_dim;
            SEG_HW:  seg_len = in_dim * h_dim;
            SEG_HB:  seg_len = h_dim;
            SEG_CW:  seg_len = h_dim * out_dim;
            SEG_CB:  seg_len = out_dim;
            default: seg_len = 0;
        endcase
    endfunction

    function automatic int unsigned frame_len(input logic        image_only,
                                              input int unsigned in_dim,
                                              input int unsigned h_dim,
                                              input int unsigned out_dim);
        if (image_only)
            frame_len = in_dim;
        else
            frame_len = in_dim + in_dim * h_dim + h_dim + h_dim * out_dim + out_dim;
    endfunction

endpackage

// File: rtl/rbm_seg_counter.sv
// Segment / element position tracker for the parameter stream.
module rbm_seg_counter
    import rbm_pkg::*;
#(
    parameter int unsigned in_dim  = 15,
    parameter int unsigned h_dim   = 5,
    parameter int unsigned out_dim = 2,
    parameter int unsigned IDX_W   = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             image_only,
    input  logic             advance,
    output logic [SEG_W-1:0] seg,
    output logic [IDX_W-1:0] idx,
    output logic             last_in_seg,
    output logic             last_in_frame
);

    logic [SEG_W-1:0] seg_q, seg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             img_only_q, img_only_d;

    // The frame mode is latched with the start request and held for the frame.
    always_comb begin
        seg_d         = seg_q;
        idx_d         = idx_q;
        img_only_d    = img_only_q;
        last_in_seg   = (idx_q == IDX_W'(seg_len(seg_q, in_dim, h_dim, out_dim) - 1));
        last_in_frame = last_in_seg &&
                        ((seg_q == SEG_CB) || (img_only_q && (seg_q == SEG_IMG)));
        if (clear) begin
            seg_d      = SEG_IMG;
            idx_d      = '0;
            img_only_d = image_only;
        end else if (advance && !last_in_frame) begin
            if (last_in_seg) begin
                seg_d = seg_q + SEG_W'(1);
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_q      <= SEG_IMG;
            idx_q      <= '0;
            img_only_q <= 1'b0;
        end else begin
            seg_q      <= seg_d;
            idx_q      <= idx_d;
            img_only_q <= img_only_d;
        end
    end

    assign seg = seg_q;
    assign idx = idx_q;

endmodule

// File: rtl/rbm_param_loader.sv
// Streams parameter words into the RBM core's packed input registers and holds
// the core in reset until a frame is loaded. Optional checksum: RBM_LOADER_CHECKSUM_EN.
module rbm_param_loader
    import rbm_pkg::*;
#(
    parameter int unsigned input_bitlength = 12,
    parameter int unsigned in_dim          = 15,
    parameter int unsigned h_dim           = 5,
    parameter int unsigned out_dim         = 2
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic                                         image_only,
    input  logic                                         s_valid,
    input  logic [input_bitlength-1:0]                   s_data,
    output logic                                         s_ready,
    output logic [in_dim*input_bitlength-1:0]            ImageI,
    output logic [in_dim*h_dim*input_bitlength-1:0]      H_WeightI,
    output logic [h_dim*input_bitlength-1:0]             H_BiasI,
    output logic [h_dim*out_dim*input_bitlength-1:0]     C_WeightI,
    output logic [out_dim*input_bitlength-1:0]           C_BiasI,
    output logic                                         main_reset,
    output logic                                         loaded,
    output logic                                         err
);

    localparam int unsigned W     = input_bitlength;
    localparam int unsigned IDX_W = $clog2(frame_len(1'b0, in_dim, h_dim, out_dim) + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
`ifdef RBM_LOADER_CHECKSUM_EN
    localparam logic [1:0] ST_CHECK = 2'd2;
`endif
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                     state_q, state_d;
    logic                           s_ready_q, s_ready_d;
    logic                           main_reset_q, main_reset_d;
    logic                           loaded_q, loaded_d;
    logic [in_dim*W-1:0]            img_q, img_d;
    logic [in_dim*h_dim*W-1:0]      hw_q, hw_d;
    logic [h_dim*W-1:0]             hb_q, hb_d;
    logic [h_dim*out_dim*W-1:0]     cw_q, cw_d;
    logic [out_dim*W-1:0]           cb_q, cb_d;
`ifdef RBM_LOADER_CHECKSUM_EN
    logic [W-1:0]                   sum_q, sum_d;
    logic                           err_q, err_d;
`endif

    logic             accept;
    logic             load_acc;
    logic             frame_start;
    logic [SEG_W-1:0] seg;
    logic [IDX_W-1:0] idx;
    logic             last_in_seg;
    logic             last_in_frame;
    logic             frame_end;

    assign accept      = s_valid && s_ready_q;
    assign load_acc    = accept && (state_q == ST_LOAD);
    assign frame_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign frame_end   = load_acc && last_in_seg && last_in_frame;

    rbm_seg_counter #(
        .in_dim  (in_dim),
        .h_dim   (h_dim),
        .out_dim (out_dim),
        .IDX_W   (IDX_W)
    ) u_seg_counter (
        .clock         (clock),
        .reset         (reset),
        .clear         (frame_start),
        .image_only    (image_only),
        .advance       (load_acc),
        .seg           (seg),
        .idx           (idx),
        .last_in_seg   (last_in_seg),
        .last_in_frame (last_in_frame)
    );

    // Next state and handshake/status flags decoded from the next state.
    always_comb begin
        state_d = state_q;
`ifdef RBM_LOADER_CHECKSUM_EN
        sum_d = sum_q;
        err_d = err_q;
        if (frame_start) begin
            sum_d = '0;
            err_d = 1'b0;
        end else if (load_acc) begin
            sum_d = sum_q + s_data;
        end
`endif
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
`ifdef RBM_LOADER_CHECKSUM_EN
            ST_LOAD:  if (frame_end) state_d = ST_CHECK;
            ST_CHECK: begin
                if (accept) begin
                    state_d = (s_data == sum_q) ? ST_DONE : ST_IDLE;
                    err_d   = (s_data != sum_q);
                end
            end
`else
            ST_LOAD:  if (frame_end) state_d = ST_DONE;
`endif
            default:  state_d = ST_IDLE;
        endcase
        s_ready_d = (state_d == ST_LOAD);
`ifdef RBM_LOADER_CHECKSUM_EN
        s_ready_d = s_ready_d || (state_d == ST_CHECK);
`endif
        main_reset_d = (state_d != ST_DONE);
        loaded_d     = (state_d == ST_DONE);
    end

    // Deposit the accepted word into the element addressed by (seg, idx).
    always_comb begin
        img_d = img_q;
        hw_d  = hw_q;
        hb_d  = hb_q;
        cw_d  = cw_q;
        cb_d  = cb_q;
        if (load_acc) begin
            case (seg)
                SEG_IMG: for (int unsigned i = 0; i < in_dim; i++)
                             if (idx == IDX_W'(i)) img_d[i*W +: W] = s_data;
                SEG_HW:  for (int unsigned i = 0; i < in_dim*h_dim; i++)
                             if (idx == IDX_W'(i)) hw_d[i*W +: W] = s_data;
                SEG_HB:  for (int unsigned i = 0; i < h_dim; i++)
                             if (idx == IDX_W'(i)) hb_d[i*W +: W] = s_data;
                SEG_CW:  for (int unsigned i = 0; i < h_dim*out_dim; i++)
                             if (idx == IDX_W'(i)) cw_d[i*W +: W] = s_data;
                SEG_CB:  for (int unsigned i = 0; i < out_dim; i++)
                             if (idx == IDX_W'(i)) cb_d[i*W +: W] = s_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            s_ready_q    <= 1'b0;
            main_reset_q <= 1'b1;
            loaded_q     <= 1'b0;
            img_q        <= '0;
            hw_q         <= '0;
            hb_q         <= '0;
            cw_q         <= '0;
            cb_q         <= '0;
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            main_reset_q <= main_reset_d;
            loaded_q     <= loaded_d;
            img_q        <= img_d;
            hw_q         <= hw_d;
            hb_q         <= hb_d;
            cw_q         <= cw_d;
            cb_q         <= cb_d;
        end
    end

`ifdef RBM_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign s_ready    = s_ready_q;
    assign main_reset = main_reset_q;
    assign loaded     = loaded_q;
    assign ImageI     = img_q;
    assign H_WeightI  = hw_q;
    assign H_BiasI    = hb_q;
    assign C_WeightI  = cw_q;
    assign C_BiasI    = cb_q;

endmodule

// File: tb/tb_rbm_param_loader.sv
// Directed bench for rbm_param_loader; honours RBM_LOADER_CHECKSUM_EN when defined.
module tb_rbm_param_loader;

    localparam int W   = 12;
    localparam int IND = 15;
    localparam int HD  = 5;
    localparam int OD  = 2;
    localparam int FULL = 107;

    logic                  clock;
    logic                  reset;
    logic                  start;
    logic                  image_only;
    logic                  s_valid;
    logic [W-1:0]          s_data;
    logic                  s_ready;
    logic [IND*W-1:0]      ImageI;
    logic [IND*HD*W-1:0]   H_WeightI;
    logic [HD*W-1:0]       H_BiasI;
    logic [HD*OD*W-1:0]    C_WeightI;
    logic [OD*W-1:0]       C_BiasI;
    logic                  main_reset;
    logic                  loaded;
    logic                  err;

    rbm_param_loader #(
        .input_bitlength (W),
        .in_dim          (IND),
        .h_dim           (HD),
        .out_dim         (OD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .image_only (image_only),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .ImageI     (ImageI),
        .H_WeightI  (H_WeightI),
        .H_BiasI    (H_BiasI),
        .C_WeightI  (C_WeightI),
        .C_BiasI    (C_BiasI),
        .main_reset (main_reset),
        .loaded     (loaded),
        .err        (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         seg;
        int         elem;
        logic [W-1:0] exp;
    } vec_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           seg_n [5] = '{15, 75, 5, 10, 2};
    logic [W-1:0] m [5][75];
    logic [W-1:0] stim [0:127];
    logic [W-1:0] sum;
    vec_t         vt [10];

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 5; s++)
            for (int e = 0; e < 75; e++)
                m[s][e] = '0;
    endtask

    // Stream position k maps onto (segment, element) in frame order.
    task automatic model_apply(input int k, input logic [W-1:0] w);
        int s = 0;
        int e = k;
        while (e >= seg_n[s]) begin
            e -= seg_n[s];
            s++;
        end
        m[s][e] = w;
    endtask

    function automatic logic [1023:0] pack_seg(input int s);
        logic [1023:0] r = '0;
        for (int e = 0; e < seg_n[s]; e++)
            r[e*W +: W] = m[s][e];
        return r;
    endfunction

    function automatic logic [1023:0] dut_seg(input int s);
        logic [1023:0] r = '0;
        case (s)
            0:       r[IND*W-1:0]    = ImageI;
            1:       r[IND*HD*W-1:0] = H_WeightI;
            2:       r[HD*W-1:0]     = H_BiasI;
            3:       r[HD*OD*W-1:0]  = C_WeightI;
            default: r[OD*W-1:0]     = C_BiasI;
        endcase
        return r;
    endfunction

    task automatic check_vectors(input string tag);
        chk_vec({tag, "_ImageI"},    dut_seg(0), pack_seg(0));
        chk_vec({tag, "_H_WeightI"}, dut_seg(1), pack_seg(1));
        chk_vec({tag, "_H_BiasI"},   dut_seg(2), pack_seg(2));
        chk_vec({tag, "_C_WeightI"}, dut_seg(3), pack_seg(3));
        chk_vec({tag, "_C_BiasI"},   dut_seg(4), pack_seg(4));
    endtask

    task automatic do_start(input logic io);
        @(negedge clock);
        start      = 1'b1;
        image_only = io;
        sum        = '0;
        @(negedge clock);
        start      = 1'b0;
        image_only = 1'b0;
    endtask

    // Drive stim[0..n-1]; optional gaps and one stray start pulse at word start_at.
    task automatic stream(input int n, input bit gaps, input int start_at,
                          output int acc, output int cyc, output bit early);
        int  k      = 0;
        bit  rdy;
        bit  pulsed = 1'b0;
        cyc   = 0;
        early = 1'b0;
        while (k < n && cyc < 4*n + 20) begin
            @(negedge clock);
            rdy = s_ready;
            if (loaded) early = 1'b1;
            s_valid    = gaps ? ~cyc[0] : 1'b1;
            s_data     = stim[k];
            start      = (k == start_at) && !pulsed;
            image_only = start;
            if (start) pulsed = 1'b1;
            @(posedge clock);
            if (s_valid && rdy) begin
                model_apply(k, stim[k]);
                sum = sum + stim[k];
                k++;
            end
            cyc++;
        end
        @(negedge clock);
        s_valid    = 1'b0;
        start      = 1'b0;
        image_only = 1'b0;
        acc        = k;
    endtask

    task automatic send_check(input logic [W-1:0] adj);
`ifdef RBM_LOADER_CHECKSUM_EN
        s_valid = 1'b1;
        s_data  = sum + adj;
        @(posedge clock);
        @(negedge clock);
        s_valid = 1'b0;
`else
        if (adj != '0) s_data = '0;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int cyc;
        bit early;

        clock = 1'b0; reset = 1'b1; start = 1'b0; image_only = 1'b0;
        s_valid = 1'b0; s_data = '0; sum = '0;
        model_reset();

        vt[0] = '{0, 0,  12'h001};
        vt[1] = '{0, 14, 12'h00F};
        vt[2] = '{1, 0,  12'h010};
        vt[3] = '{1, 74, 12'h05A};
        vt[4] = '{2, 0,  12'h05B};
        vt[5] = '{2, 4,  12'h05F};
        vt[6] = '{3, 0,  12'h060};
        vt[7] = '{3, 9,  12'h069};
        vt[8] = '{4, 0,  12'h06A};
        vt[9] = '{4, 1,  12'h06B};

        // Reset state
        repeat (2) @(negedge clock);
        chk_int("rst_s_ready",    int'(s_ready),    0);
        chk_int("rst_main_reset", int'(main_reset), 1);
        chk_int("rst_loaded",     int'(loaded),     0);
        chk_int("rst_err",        int'(err),        0);
        check_vectors("rst");
        reset = 1'b0;

        // Gap-free full frame, word n = n+1
        for (int k = 0; k < FULL; k++) stim[k] = W'(k + 1);
        do_start(1'b0);
        stream(FULL, 1'b0, -1, acc, cyc, early);
        send_check('0);
        chk_int("full_accepts",   acc, FULL);
        chk_int("full_cycles",    cyc, FULL);
        chk_int("full_early",     int'(early), 0);
        chk_int("full_loaded",    int'(loaded), 1);
        chk_int("full_main_rst",  int'(main_reset), 0);
        chk_int("full_s_ready",   int'(s_ready), 0);
        chk_int("full_err",       int'(err), 0);
        for (int i = 0; i < 10; i++) begin
            logic [1023:0] v;
            v = dut_seg(vt[i].seg);
            chk_int($sformatf("elem_s%0d_e%0d", vt[i].seg, vt[i].elem),
                    int'(v[vt[i].elem*W +: W]), int'(vt[i].exp));
        end
        check_vectors("full");

        // Same frame with s_valid toggling every cycle
        @(negedge clock); reset = 1'b1; model_reset();
        @(negedge clock); reset = 1'b0;
        do_start(1'b0);
        stream(FULL, 1'b1, -1, acc, cyc, early);
        send_check('0);
        chk_int("gaps_accepts", acc, FULL);
        chk_int("gaps_early",   int'(early), 0);
        chk_int("gaps_loaded",  int'(loaded), 1);
        check_vectors("gaps");

        // Image-only reload with all-ones
        for (int k = 0; k < IND; k++) stim[k] = 12'hFFF;
        do_start(1'b1);
        stream(IND, 1'b0, -1, acc, cyc, early);
        send_check('0);
        chk_int("img_accepts",  acc, IND);
        chk_int("img_cycles",   cyc, IND);
        chk_int("img_loaded",   int'(loaded), 1);
        chk_int("img_main_rst", int'(main_reset), 0);
        check_vectors("img");

        // Reset after word 40, then a fresh frame
        for (int k = 0; k < FULL; k++) stim[k] = W'(k) ^ 12'hA5A;
        do_start(1'b0);
        stream(40, 1'b0, -1, acc, cyc, early);
        reset = 1'b1;
        model_reset();
        #1;
        chk_int("mid_rst_s_ready",    int'(s_ready), 0);
        chk_int("mid_rst_main_reset", int'(main_reset), 1);
        chk_int("mid_rst_loaded",     int'(loaded), 0);
        check_vectors("mid_rst");
        @(negedge clock); reset = 1'b0;
        for (int k = 0; k < FULL; k++) stim[k] = W'(k * 7 + 3);
        do_start(1'b0);
        stream(FULL, 1'b0, -1, acc, cyc, early);
        send_check('0);
        chk_int("reload_accepts", acc, FULL);
        chk_int("reload_loaded",  int'(loaded), 1);
        check_vectors("reload");

        // Stray start pulse at word 20 is ignored
        for (int k = 0; k < FULL; k++) stim[k] = W'(k * 13 + 1);
        do_start(1'b0);
        stream(FULL, 1'b0, 20, acc, cyc, early);
        send_check('0);
        chk_int("stray_accepts", acc, FULL);
        chk_int("stray_early",   int'(early), 0);
        chk_int("stray_loaded",  int'(loaded), 1);
        check_vectors("stray");

`ifdef RBM_LOADER_CHECKSUM_EN
        // Wrong checksum: back to IDLE with err, data kept
        for (int k = 0; k < FULL; k++) stim[k] = W'(k * 5 + 9);
        do_start(1'b0);
        stream(FULL, 1'b0, -1, acc, cyc, early);
        send_check(12'h001);
        chk_int("bad_ck_err",      int'(err), 1);
        chk_int("bad_ck_loaded",   int'(loaded), 0);
        chk_int("bad_ck_main_rst", int'(main_reset), 1);
        chk_int("bad_ck_s_ready",  int'(s_ready), 0);
        check_vectors("bad_ck");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
